// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the edge rasteriser.
//   raster_state_t : controller states
//   vertex_t       : one triangle vertex {x, y}
//   min3()         : smallest of three coordinates, used to place the bitmap origin
package gpu_raster_pkg;

    localparam int GRID_DIM   = 64;
    localparam int COORD_BITS = 8;
    localparam int GRID_BITS  = $clog2(GRID_DIM);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EDGE_INIT,
        EDGE_STEP,
        NEXT_EDGE,
        DONE
    } raster_state_t;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } vertex_t;

    function automatic logic [COORD_BITS-1:0] min3(
        input logic [COORD_BITS-1:0] a,
        input logic [COORD_BITS-1:0] b,
        input logic [COORD_BITS-1:0] c
    );
        logic [COORD_BITS-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/edge_raster_line_stepper.sv
// Bresenham line walker, one pixel per step.
//   clk, rst : clock and synchronous active-high reset
//   load     : initialise a new line from pa to pb
//   step     : advance one pixel towards pb
//   pa, pb   : line start and end vertices (sampled on load)
//   cur_x/y  : current pixel position
//   at_end   : current pixel is the end vertex
module line_stepper
    import gpu_raster_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  vertex_t               pa,
    input  vertex_t               pb,
    output logic [COORD_BITS-1:0] cur_x,
    output logic [COORD_BITS-1:0] cur_y,
    output logic                  at_end
);

    logic [COORD_BITS-1:0] x, y, xb, yb;
    logic signed [8:0]     dx, dy;
    logic signed [10:0]    err;
    logic                  sx_neg, sy_neg;

    logic [COORD_BITS-1:0] adx, ady;
    logic signed [8:0]     dx_init, dy_init;
    logic signed [10:0]    err_init, err_nxt;
    logic signed [11:0]    e2, dx_w, dy_w;
    logic                  x_move, y_move;

    // Line setup: dx is non-negative, dy is non-positive, err starts at dx+dy.
    always_comb begin
        adx      = (pa.x > pb.x) ? pa.x - pb.x : pb.x - pa.x;
        ady      = (pa.y > pb.y) ? pa.y - pb.y : pb.y - pa.y;
        dx_init  = $signed({1'b0, adx});
        dy_init  = -$signed({1'b0, ady});
        err_init = {{2{dx_init[8]}}, dx_init} + {{2{dy_init[8]}}, dy_init};
    end

    // Both axis decisions use the error value from before this step.
    always_comb begin
        e2      = {err, 1'b0};
        dx_w    = {{3{dx[8]}}, dx};
        dy_w    = {{3{dy[8]}}, dy};
        x_move  = (e2 >= dy_w);
        y_move  = (e2 <= dx_w);
        err_nxt = err + (x_move ? {{2{dy[8]}}, dy} : 11'sd0)
                      + (y_move ? {{2{dx[8]}}, dx} : 11'sd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            xb     <= '0;
            yb     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            x      <= pa.x;
            y      <= pa.y;
            xb     <= pb.x;
            yb     <= pb.y;
            dx     <= dx_init;
            dy     <= dy_init;
            err    <= err_init;
            sx_neg <= !(pa.x < pb.x);
            sy_neg <= !(pa.y < pb.y);
        end else if (step) begin
            err <= err_nxt;
            if (x_move) x <= sx_neg ? x - 8'd1 : x + 8'd1;
            if (y_move) y <= sy_neg ? y - 8'd1 : y + 8'd1;
        end
    end

    assign cur_x  = x;
    assign cur_y  = y;
    assign at_end = (x == xb) && (y == yb);

endmodule

// File: rtl/edge_raster.sv
// Draws the three edges of a triangle into a 64x64 bitmap whose origin is the
// triangle's (xmin, ymin) corner, one pixel per clock.
//   clk, rst    : clock and synchronous active-high reset
//   raster_en   : start request, honoured only while idle
//   coordinates : {y2,x2,y1,x1,y0,x0}, 8 bits each
//   line_buffer : bitmap, bit (row*64+col) set for an edge pixel
//   busy        : high whenever not idle
//   raster_done : one-cycle pulse when line_buffer is complete
module edge_raster
    import gpu_raster_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           raster_en,
    input  logic [6*COORD_BITS-1:0]        coordinates,
    output logic [GRID_DIM*GRID_DIM-1:0]   line_buffer,
    output logic                           busy,
    output logic                           raster_done
);

    raster_state_t         state, state_nxt;
    vertex_t               vtx [3];
    logic [COORD_BITS-1:0] xmin, ymin;
    logic [1:0]            edge_idx;

    vertex_t               pa, pb;
    logic                  load, step, at_end;
    logic [COORD_BITS-1:0] cur_x, cur_y;

    logic [COORD_BITS-1:0]      col, row;
    logic                       plot_hit;
    logic [2*GRID_BITS-1:0]     plot_idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        raster_done = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        case (state)
            IDLE:      if (raster_en) state_nxt = SETUP;
            SETUP:     state_nxt = EDGE_INIT;
            EDGE_INIT: begin
                load      = 1'b1;
                state_nxt = EDGE_STEP;
            end
            EDGE_STEP: begin
                if (at_end) state_nxt = NEXT_EDGE;
                else        step      = 1'b1;
            end
            NEXT_EDGE: state_nxt = (edge_idx == 2'd2) ? DONE : EDGE_INIT;
            DONE: begin
                raster_done = 1'b1;
                state_nxt   = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Edges run v0->v1, v1->v2, v2->v0.
    always_comb begin
        pa = vtx[0];
        pb = vtx[1];
        case (edge_idx)
            2'd1: begin pa = vtx[1]; pb = vtx[2]; end
            2'd2: begin pa = vtx[2]; pb = vtx[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) vtx[i] <= '0;
            xmin     <= '0;
            ymin     <= '0;
            edge_idx <= '0;
        end else if (state == SETUP) begin
            for (int i = 0; i < 3; i++) begin
                vtx[i].x <= coordinates[16*i +: COORD_BITS];
                vtx[i].y <= coordinates[16*i+8 +: COORD_BITS];
            end
            xmin     <= min3(coordinates[7:0], coordinates[23:16], coordinates[39:32]);
            ymin     <= min3(coordinates[15:8], coordinates[31:24], coordinates[47:40]);
            edge_idx <= '0;
        end else if (state == NEXT_EDGE && edge_idx != 2'd2) begin
            edge_idx <= edge_idx + 2'd1;
        end
    end

    line_stepper u_stepper (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .pa     (pa),
        .pb     (pb),
        .cur_x  (cur_x),
        .cur_y  (cur_y),
        .at_end (at_end)
    );

    // Every line pixel lies at or above the minimum corner, so the offsets
    // never go negative; pixels beyond the grid are simply dropped.
    always_comb begin
        col      = cur_x - xmin;
        row      = cur_y - ymin;
        plot_hit = (state == EDGE_STEP)
                && (col < COORD_BITS'(GRID_DIM)) && (row < COORD_BITS'(GRID_DIM));
        plot_idx = {row[GRID_BITS-1:0], col[GRID_BITS-1:0]};
    end

    // NOTE: the bitmap is an architectural output that must read zero out of
    // reset, so it is a reset register rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst)                 line_buffer <= '0;
        else if (state == SETUP) line_buffer <= '0;
        else if (plot_hit)       line_buffer[plot_idx] <= 1'b1;
    end

endmodule

// File: tb/tb_edge_raster.sv
module tb_edge_raster;

    logic          clk = 1'b0;
    logic          rst;
    logic          raster_en;
    logic [47:0]   coordinates;
    logic [4095:0] line_buffer;
    logic          busy;
    logic          raster_done;

    int checks = 0;
    int errors = 0;

    edge_raster dut (
        .clk         (clk),
        .rst         (rst),
        .raster_en   (raster_en),
        .coordinates (coordinates),
        .line_buffer (line_buffer),
        .busy        (busy),
        .raster_done (raster_done)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack3(input int x0, input int y0, input int x1,
                                          input int y1, input int x2, input int y2);
        return {8'(y2), 8'(x2), 8'(y1), 8'(x1), 8'(y0), 8'(x0)};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: Bresenham over plain integers, with clipping to the 64x64 window.
    // Returns the expected latency from the IDLE cycle that sees raster_en.
    function automatic int model(input logic [47:0] c, output logic [4095:0] bm);
        int xs[3], ys[3];
        int xmin, ymin, lat;
        bm = '0;
        for (int i = 0; i < 3; i++) begin
            xs[i] = int'(c[16*i +: 8]);
            ys[i] = int'(c[16*i+8 +: 8]);
        end
        xmin = xs[0]; ymin = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
        end
        lat = 2;
        for (int e = 0; e < 3; e++) begin
            int xa, ya, xb, yb, dx, dy, sx, sy, err, e2, x, y, guard;
            xa = xs[e]; ya = ys[e]; xb = xs[(e+1)%3]; yb = ys[(e+1)%3];
            dx = iabs(xb - xa); dy = -iabs(yb - ya);
            lat += 3 + ((dx > -dy) ? dx : -dy);
            sx = (xa < xb) ? 1 : -1; sy = (ya < yb) ? 1 : -1;
            err = dx + dy; x = xa; y = ya; guard = 0;
            while (guard < 1000) begin
                if (x - xmin < 64 && y - ymin < 64) bm[(y - ymin)*64 + (x - xmin)] = 1'b1;
                if (x == xb && y == yb) break;
                e2 = 2*err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
                guard++;
            end
        end
        return lat;
    endfunction

    function automatic int first_diff(input logic [4095:0] a, input logic [4095:0] b);
        for (int i = 0; i < 4096; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic cmp_bitmap(input string name, input logic [4095:0] exp);
        checks++;
        if (line_buffer !== exp) begin
            errors++;
            $display("FAIL %s: bitmap got %0d set bits, expected %0d, first difference at bit %0d",
                     name, $countones(line_buffer), $countones(exp), first_diff(line_buffer, exp));
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Starts a raster and returns cycles until raster_done (or -1 on timeout).
    task automatic run_raster(input logic [47:0] c, output int cycles);
        coordinates = c;
        raster_en   = 1'b1;
        cycles      = -1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk); #1;
            raster_en = 1'b0;
            if (raster_done) begin cycles = n; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; raster_en = 1'b0; coordinates = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp_bitmap("reset_buffer", '0);
        cmp_int("reset_busy", int'(busy), 0);
        cmp_int("reset_done", int'(raster_done), 0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_point;
        int cyc;
        logic [4095:0] exp;
        exp = '0; exp[0] = 1'b1;
        run_raster(pack3(10, 20, 10, 20, 10, 20), cyc);
        cmp_int("point_latency", cyc, 11);
        cmp_bitmap("point_bitmap", exp);
        @(posedge clk); #1;
    endtask

    task automatic test_small_triangle;
        int cyc, lat;
        logic [4095:0] exp, mdl;
        int px[9] = '{0, 1, 2, 3, 0, 0, 0, 2, 1};
        int py[9] = '{0, 0, 0, 0, 1, 2, 3, 1, 2};
        exp = '0;
        for (int i = 0; i < 9; i++) exp[py[i]*64 + px[i]] = 1'b1;
        lat = model(pack3(0, 0, 3, 0, 0, 3), mdl);
        run_raster(pack3(0, 0, 3, 0, 0, 3), cyc);
        cmp_int("tri_latency", cyc, lat);
        cmp_int("tri_popcount", $countones(line_buffer), 9);
        cmp_bitmap("tri_bitmap", exp);
        @(posedge clk); #1;
        cmp_int("tri_busy_after", int'(busy), 0);
        cmp_bitmap("tri_hold", exp);
    endtask

    task automatic test_clipping;
        int cyc, lat;
        logic [4095:0] mdl;
        lat = model(pack3(0, 0, 100, 0, 0, 5), mdl);
        run_raster(pack3(0, 0, 100, 0, 0, 5), cyc);
        cmp_int("clip_latency", cyc, 216);
        cmp_int("clip_latency_model", cyc, lat);
        cmp_int("clip_row0_full", int'(&line_buffer[63:0]), 1);
        cmp_int("clip_col0", int'(line_buffer[64] & line_buffer[128] & line_buffer[192]
                                  & line_buffer[256] & line_buffer[320]), 1);
        cmp_int("clip_row1_cols1to7", int'(|line_buffer[71:65]), 0);
        cmp_bitmap("clip_bitmap", mdl);
        @(posedge clk); #1;
    endtask

    task automatic test_en_while_busy;
        int pulses, lat;
        logic [4095:0] mdl;
        lat = model(pack3(5, 5, 30, 12, 9, 40), mdl);
        coordinates = pack3(5, 5, 30, 12, 9, 40);
        raster_en = 1'b1;
        @(posedge clk); #1;
        raster_en = 1'b0;
        pulses = 0;
        repeat (6) begin @(posedge clk); #1; end
        coordinates = pack3(200, 1, 2, 3, 77, 90);
        raster_en = 1'b1;
        @(posedge clk); #1;
        raster_en = 1'b0;
        for (int n = 0; n < lat + 20; n++) begin
            if (raster_done) pulses++;
            @(posedge clk); #1;
        end
        cmp_int("busy_en_pulses", pulses, 1);
        cmp_bitmap("busy_en_bitmap", mdl);
        cmp_int("busy_en_idle", int'(busy), 0);
    endtask

    task automatic test_reset_mid;
        int cyc, lat;
        logic [47:0] c;
        logic [4095:0] mdl;
        coordinates = pack3(0, 0, 40, 0, 0, 40);
        raster_en = 1'b1;
        @(posedge clk); #1;
        raster_en = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_bitmap("midrst_buffer", '0);
        cmp_int("midrst_busy", int'(busy), 0);
        cmp_int("midrst_done", int'(raster_done), 0);
        c = pack3($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50),
                  $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50));
        lat = model(c, mdl);
        run_raster(c, cyc);
        cmp_int("midrst_rerun_latency", cyc, lat);
        cmp_bitmap("midrst_rerun_bitmap", mdl);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n1, n2, pulses, lat_a, lat_b;
        logic [47:0] ca, cb;
        logic [4095:0] ma, mb;
        ca = pack3(3, 60, 50, 2, 20, 30);
        cb = pack3(100, 100, 110, 103, 104, 120);
        lat_a = model(ca, ma);
        lat_b = model(cb, mb);
        coordinates = ca;
        raster_en = 1'b1;
        n1 = -1; n2 = -1; pulses = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            if (raster_done) begin n1 = n; pulses++; break; end
        end
        cmp_bitmap("b2b_first_bitmap", ma);
        coordinates = cb;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            if (raster_done) begin n2 = n; pulses++; break; end
        end
        raster_en = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (raster_done) pulses++;
        end
        cmp_int("b2b_first_latency", n1, lat_a);
        cmp_int("b2b_second_latency", n2, lat_b + 1);
        cmp_int("b2b_pulses", pulses, 2);
        cmp_bitmap("b2b_final_bitmap", mb);
    endtask

    task automatic test_random;
        int cyc, lat, base_x, base_y, span;
        logic [47:0] c;
        logic [4095:0] mdl;
        for (int t = 0; t < 8; t++) begin
            span   = (t < 5) ? 63 : 255;
            base_x = $urandom_range(0, 255 - span);
            base_y = $urandom_range(0, 255 - span);
            c = pack3(base_x + $urandom_range(0, span), base_y + $urandom_range(0, span),
                      base_x + $urandom_range(0, span), base_y + $urandom_range(0, span),
                      base_x + $urandom_range(0, span), base_y + $urandom_range(0, span));
            lat = model(c, mdl);
            run_raster(c, cyc);
            cmp_int($sformatf("rand%0d_latency", t), cyc, lat);
            cmp_bitmap($sformatf("rand%0d_bitmap", t), mdl);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_single_point;
        test_small_triangle;
        test_clipping;
        test_en_while_busy;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
